// File: rtl/matrix_load_sequencer.sv
// Write-side sequencer for the 32-column dot-matrix pattern store.
// Arbitrates two column requesters plus an internal clear-all sequence onto the
// single column_id/in_column/LOAD port. Each write is spaced as setup, strobe,
// hold and a one-cycle done phase, so the store's LOAD rising edge always sees
// stable id and data.
// Optional build macro MATRIX_SEQ_LOCK_EN adds lock0/lock1. A requester that
// holds its lock during its done cycle keeps the port for back-to-back writes.
module matrix_load_sequencer #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic        CLK,
  input  logic        RESET_N,
`ifdef MATRIX_SEQ_LOCK_EN
  input  logic        lock0,
  input  logic        lock1,
`endif
  input  logic        req0,
  input  logic [4:0]  id0,
  input  logic [15:0] data0,
  output logic        ack0,
  input  logic        req1,
  input  logic [4:0]  id1,
  input  logic [15:0] data1,
  output logic        ack1,
  input  logic        clr_req,
  output logic        clr_busy,
  output logic        busy,
  output logic [4:0]  column_id,
  output logic [15:0] in_column,
  output logic        LOAD
);

  localparam int unsigned MaxAb  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int unsigned MaxCyc = (MaxAb > HOLD_CYC) ? MaxAb : HOLD_CYC;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  localparam logic [CntW-1:0] SetupLast  = CntW'(SETUP_CYC - 1);
  localparam logic [CntW-1:0] StrobeLast = CntW'(STROBE_CYC - 1);
  localparam logic [CntW-1:0] HoldLast   = CntW'(HOLD_CYC - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            gnt_q, gnt_d;      // requester owning the current write
  logic            rr_q, rr_d;        // preferred requester on contention
  logic            clr_q, clr_d;
  logic [4:0]      clr_cnt_q, clr_cnt_d;
  logic [4:0]      col_q, col_d;
  logic [15:0]     dat_q, dat_d;
  logic            pick;
`ifdef MATRIX_SEQ_LOCK_EN
  logic            lock_q, lock_d;    // last owner asked to keep the port
`endif

  // Requester selection for an IDLE cycle: lock re-grant, else round-robin.
  always_comb begin
    pick = 1'b0;
`ifdef MATRIX_SEQ_LOCK_EN
    if (lock_q && (gnt_q ? req1 : req0)) begin
      pick = gnt_q;
    end else
`endif
    if (req0 && req1) begin
      pick = rr_q;
    end else begin
      pick = req1;
    end
  end

  // Next-state logic for the write/clear sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    rr_d      = rr_q;
    clr_d     = clr_q;
    clr_cnt_d = clr_cnt_q;
    col_d     = col_q;
    dat_d     = dat_q;
`ifdef MATRIX_SEQ_LOCK_EN
    lock_d    = lock_q;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
`ifdef MATRIX_SEQ_LOCK_EN
        lock_d = 1'b0;  // a lock only carries into the very next idle cycle
`endif
        if (clr_req) begin
          clr_d     = 1'b1;
          clr_cnt_d = 5'd0;
          col_d     = 5'd0;
          dat_d     = 16'd0;
          state_d   = StSetup;
        end else if (req0 || req1) begin
          gnt_d   = pick;
          col_d   = pick ? id1 : id0;
          dat_d   = pick ? data1 : data0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) begin
          cnt_d   = '0;
          state_d = StStrobe;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStrobe: begin
        if (cnt_q == StrobeLast) begin
          cnt_d   = '0;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (clr_q) begin
          if (clr_cnt_q != 5'd31) begin
            clr_cnt_d = clr_cnt_q + 5'd1;
            col_d     = clr_cnt_q + 5'd1;
            dat_d     = 16'd0;
            state_d   = StSetup;
          end else begin
            clr_d   = 1'b0;
            state_d = StIdle;
          end
        end else begin
          state_d = StIdle;
`ifdef MATRIX_SEQ_LOCK_EN
          if (gnt_q ? lock1 : lock0) begin
            lock_d = 1'b1;
          end else begin
            rr_d = ~gnt_q;
          end
`else
          rr_d = ~gnt_q;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset abandons any write or clear immediately.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      gnt_q     <= 1'b0;
      rr_q      <= 1'b0;
      clr_q     <= 1'b0;
      clr_cnt_q <= 5'd0;
      col_q     <= 5'd0;
      dat_q     <= 16'd0;
`ifdef MATRIX_SEQ_LOCK_EN
      lock_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      rr_q      <= rr_d;
      clr_q     <= clr_d;
      clr_cnt_q <= clr_cnt_d;
      col_q     <= col_d;
      dat_q     <= dat_d;
`ifdef MATRIX_SEQ_LOCK_EN
      lock_q    <= lock_d;
`endif
    end
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    LOAD      = (state_q == StStrobe);
    busy      = (state_q != StIdle);
    clr_busy  = clr_q;
    ack0      = (state_q == StDone) && !clr_q && !gnt_q;
    ack1      = (state_q == StDone) && !clr_q && gnt_q;
    column_id = col_q;
    in_column = dat_q;
  end

endmodule

// File: tb/tb_matrix_load_sequencer.sv
// Randomized bench for matrix_load_sequencer with a transaction-offset reference
// model, plus a directed latency check on a second instance with non-default spacing.
module tb_matrix_load_sequencer;

  localparam int S  = 1;
  localparam int ST = 2;
  localparam int H  = 1;
  localparam int T  = S + ST + H + 1;  // cycles per column write incl. done
  localparam int S2  = 3;
  localparam int ST2 = 1;
  localparam int H2  = 2;
  localparam int T2  = S2 + ST2 + H2 + 1;

  logic CLK = 1'b0;
  logic RESET_N;
  logic req0, req1, clr_req, lock0, lock1;
  logic [4:0] id0, id1;
  logic [15:0] data0, data1;
  logic ack0, ack1, clr_busy, busy, LOAD;
  logic [4:0] column_id;
  logic [15:0] in_column;

  logic b_req0, b_req1, b_ack0, b_ack1, b_clr_busy, b_busy, b_load;
  logic [4:0] b_id0, b_id1, b_col;
  logic [15:0] b_data0, b_data1, b_incol;

  int n_checks = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  matrix_load_sequencer #(.SETUP_CYC(S), .STROBE_CYC(ST), .HOLD_CYC(H)) u_dut (
    .CLK(CLK), .RESET_N(RESET_N),
`ifdef MATRIX_SEQ_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .req0(req0), .id0(id0), .data0(data0), .ack0(ack0),
    .req1(req1), .id1(id1), .data1(data1), .ack1(ack1),
    .clr_req(clr_req), .clr_busy(clr_busy), .busy(busy),
    .column_id(column_id), .in_column(in_column), .LOAD(LOAD)
  );

  matrix_load_sequencer #(.SETUP_CYC(S2), .STROBE_CYC(ST2), .HOLD_CYC(H2)) u_dut2 (
    .CLK(CLK), .RESET_N(RESET_N),
`ifdef MATRIX_SEQ_LOCK_EN
    .lock0(1'b0), .lock1(1'b0),
`endif
    .req0(b_req0), .id0(b_id0), .data0(b_data0), .ack0(b_ack0),
    .req1(b_req1), .id1(b_id1), .data1(b_data1), .ack1(b_ack1),
    .clr_req(1'b0), .clr_busy(b_clr_busy), .busy(b_busy),
    .column_id(b_col), .in_column(b_incol), .LOAD(b_load)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: m_k is the offset inside the current column write (0 = idle).
  int          m_k;
  bit          m_clr, m_gnt, m_rr, m_lock;
  int          m_col;
  logic [4:0]  m_id;
  logic [15:0] m_data;

  function automatic void model_reset();
    m_k = 0; m_clr = 0; m_gnt = 0; m_rr = 0; m_lock = 0;
    m_col = 0; m_id = 5'd0; m_data = 16'd0;
  endfunction

  // Advance the model by one clock edge using the inputs seen at that edge.
  function automatic void model_step();
    bit w;
    if (m_k == 0) begin
      if (clr_req) begin
        m_clr = 1; m_col = 0; m_id = 5'd0; m_data = 16'd0; m_k = 1;
      end else if (req0 || req1) begin
        if (m_lock && (m_gnt ? req1 : req0)) w = m_gnt;
        else if (req0 && req1) w = m_rr;
        else w = req1;
        m_gnt = w;
        m_id = w ? id1 : id0;
        m_data = w ? data1 : data0;
        m_k = 1;
      end
      m_lock = 0;
    end else if (m_k == T) begin
      if (m_clr) begin
        if (m_col < 31) begin
          m_col++; m_id = 5'(m_col); m_data = 16'd0; m_k = 1;
        end else begin
          m_clr = 0; m_k = 0;
        end
      end else begin
        m_k = 0;
`ifdef MATRIX_SEQ_LOCK_EN
        if (m_gnt ? lock1 : lock0) m_lock = 1;
        else m_rr = !m_gnt;
`else
        m_rr = !m_gnt;
`endif
      end
    end else begin
      m_k++;
    end
  endfunction

  function automatic bit exp_load();
    return (m_k > S) && (m_k <= S + ST);
  endfunction

  initial begin
    bit a0_seen, a1_seen, prev_load, reset_pending;
    int load_rises, clr_cycles, ack1_cnt;
    logic [15:0] pat;
    a0_seen = 0; a1_seen = 0; prev_load = 0; reset_pending = 0;
    load_rises = 0; clr_cycles = 0; ack1_cnt = 0;
    RESET_N = 1'b0;
    req0 = 0; req1 = 0; clr_req = 0; lock0 = 0; lock1 = 0;
    id0 = 0; id1 = 0; data0 = 0; data1 = 0;
    b_req0 = 0; b_req1 = 0; b_id0 = 0; b_id1 = 0; b_data0 = 0; b_data1 = 0;
    model_reset();

    @(negedge CLK);
    check_eq("rst_load", LOAD, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_clr_busy", clr_busy, 0);
    check_eq("rst_acks", {ack0, ack1}, 0);
    check_eq("rst_col", column_id, 0);
    check_eq("rst_incol", in_column, 0);
    @(posedge CLK);
    #1 RESET_N = 1'b1;

    for (int cyc = 0; cyc < 8000; cyc++) begin
      @(posedge CLK);
      if (RESET_N) model_step();
      #1;
      if (!RESET_N) RESET_N = 1'b1;
      // Stimulus: requesters hold until acked; phase 0 is the directed clear.
      if (req0 && a0_seen) req0 = 0;
      else if (!req0 && cyc >= 200 && $urandom_range(0, 2) == 0) begin
        req0 = 1; id0 = 5'($urandom); data0 = 16'($urandom);
      end else if (req0 && !busy && $urandom_range(0, 9) == 0) data0 = 16'($urandom);
      if (req1 && a1_seen) req1 = 0;
      else if (!req1 && cyc >= 200 && $urandom_range(0, 2) == 0) begin
        req1 = 1; id1 = 5'($urandom); data1 = 16'($urandom);
      end
      if (cyc == 0) begin
        clr_req = 1; req1 = 1; id1 = 5'd3; data1 = 16'h1234;
      end else begin
        clr_req = (cyc >= 200) && ($urandom_range(0, 59) == 0);
      end
      lock0 = ($urandom_range(0, 3) != 0);
      lock1 = ($urandom_range(0, 3) == 0);
      if (cyc == 2000 || cyc == 5000) reset_pending = 1;

      @(negedge CLK);
      check_eq("load", LOAD, exp_load());
      check_eq("busy", busy, m_k != 0);
      check_eq("clr_busy", clr_busy, m_clr);
      check_eq("ack0", ack0, (m_k == T) && !m_clr && !m_gnt);
      check_eq("ack1", ack1, (m_k == T) && !m_clr && m_gnt);
      check_eq("column_id", column_id, m_id);
      check_eq("in_column", in_column, m_data);
      a0_seen = ack0; a1_seen = ack1;

      if (cyc < 200) begin
        if (LOAD && !prev_load && clr_busy) load_rises++;
        if (clr_busy) clr_cycles++;
        if (ack1) ack1_cnt++;
      end
      prev_load = LOAD;
      if (cyc == 199) begin
        check_eq("clr_load_pulses", load_rises, 32);
        check_eq("clr_busy_cycles", clr_cycles, 160);
        check_eq("clr_then_ack1", ack1_cnt, 1);
      end

      if (reset_pending && exp_load()) begin
        reset_pending = 0;
        #1 RESET_N = 1'b0;
        #1;
        check_eq("mid_rst_load", LOAD, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_clr_busy", clr_busy, 0);
        check_eq("mid_rst_col", column_id, 0);
        check_eq("mid_rst_acks", {ack0, ack1}, 0);
        model_reset();
        req0 = 0; req1 = 0; clr_req = 0;
        a0_seen = 0; a1_seen = 0; prev_load = 0;
      end
    end

    // Second instance: SETUP=3, STROBE=1, HOLD=2, one write from each requester.
    req0 = 0; req1 = 0; clr_req = 0;
    for (int r = 0; r < 2; r++) begin
      @(posedge CLK);
      #1;
      pat = 16'($urandom);
      if (r == 0) begin b_req0 = 1; b_id0 = 5'd9; b_data0 = pat; end
      else begin b_req1 = 1; b_id1 = 5'd22; b_data1 = pat; end
      @(posedge CLK);  // arbitration edge
      for (int k = 1; k <= T2 + 2; k++) begin
        @(negedge CLK);
        check_eq("p2_load", b_load, (k > S2) && (k <= S2 + ST2));
        check_eq("p2_ack", {b_ack1, b_ack0}, (k == T2) ? (r == 0 ? 2'b01 : 2'b10) : 2'b00);
        check_eq("p2_busy", b_busy, k <= T2);
        if (k <= T2) begin
          check_eq("p2_col", b_col, (r == 0) ? 5'd9 : 5'd22);
          check_eq("p2_incol", b_incol, pat);
        end
        if (k == T2) begin b_req0 = 0; b_req1 = 0; end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
